regfile_p: RTL and testbench
============================

# regfile_p

Parametrised successor to the picoMIPS 4-entry register file. It provides 2^A general-purpose registers of N bits each, with two asynchronous read ports and one synchronous write port, and register %0 hardwired to zero. After reset, or on request, a sequential clear engine zeroes the array one entry per cycle and holds `ready` low until done. An optional write-to-read bypass is available. It sits between the decoder (addresses and `w`) and the ALU operand muxes / writeback path.

## Interface
- `N`, 8, data width in bits
- `A`, 3, address width; register count is 2^A (minimum A=1)
- `clk`  in  1  system clock; all state changes on rising edge
- `nReset`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous request to re-zero all registers
- `w`  in  1  write enable
- `Waddr`  in  A  write address
- `Wdata`  in  N  write data
- `Raddr1`  in  A  read address, port 1
- `Raddr2`  in  A  read address, port 2
- `Rdata1`  out  N  read data, port 1
- `Rdata2`  out  N  read data, port 2
- `ready`  out  1  high when the array is valid and writes are accepted

## Operation
- The storage array is not reset, so it can infer distributed RAM.
- Reset acts only on the FSM, the clear counter `cc` (A bits) and `ready`.
- FSM states:
  - CLEAR: each edge writes 0 to `gpr[cc]`, then `cc <= cc+1`. When `cc == 2^A-1` is written, the next state is RUN. `cc` is never 0, because %0 is not stored.
  - RUN: a normal write occurs on the edge when `w=1` and `Waddr != 0`.
- `clr=1` in RUN: the next state is CLEAR with `cc=1`. `clr` takes priority, so a simultaneous `w` is discarded.
- `clr=1` in CLEAR: `cc` restarts at 1.
- `ready = (state == RUN)`, registered.
- In CLEAR, `w` is ignored.
- Reads: `Rdata = 0` if the address is 0 or `ready=0`; otherwise `gpr[addr]`.
- A write to %0 is silently dropped, and reads of %0 always return 0.
- There is no address range checking; the address width covers all entries exactly.

## Timing
- Reset (`nReset=0`): state CLEAR, `cc=1`, `ready=0`, `Rdata1`=`Rdata2`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-CLEAR or mid-RUN: the clear restarts from `cc=1` after release. Array contents are undefined until the clear completes.
- Clear latency: 2^A-1 rising edges after `nReset` deasserts, or after the edge that samples `clr`. `ready` rises with the last of those edges; for A=3 that is the 7th edge.
- Write latency: 1 edge. Data written at edge k is visible on the read ports after edge k.
- Reads are combinational from address to data, with zero cycles latency.
- Same-cycle write and read to the same address: the result depends on `REGS_BYPASS_EN` (see Configuration).
- Both read ports may address the same register simultaneously and must return identical data.

## Configuration
- `REGS_BYPASS_EN` defined:
  - When `ready=1`, `w=1`, `Waddr != 0` and `Raddr == Waddr`, the port returns `Wdata` combinationally in the same cycle.
  - Applies independently to each read port.
- `REGS_BYPASS_EN` undefined: reads return the pre-edge array contents; the new value appears after the write edge.
- In both cases the zero rules take precedence over the bypass (address 0, or `ready=0`, gives 0).

## Test plan
- Reset then clear, N=8, A=3: release `nReset`, sample `ready` → low for 6 edges, high after the 7th. Then read all 8 registers → all 0x00.
- %0 protection: write 0xAA to address 0, read `Raddr1=0` → 0x00. Write 0x5C to r3, read both ports at r3 → 0x5C on each.
- Same-cycle hazard: write 0x3F to r5 while `Raddr2=5`, old r5=0x11. Pre-edge `Rdata2`: 0x3F with `REGS_BYPASS_EN`, 0x11 without. Post-edge: 0x3F in both builds.
- `clr` with simultaneous write in RUN: r2=0x77, assert `clr` and `w` (r4←0x99) together. Expect `ready` low for the next 7 edges, r2 and r4 both read 0x00 afterwards, and the write dropped.
- Async reset mid-CLEAR: pulse `nReset` low between edges at `cc=4`. `ready` must stay 0 and `Rdata`=0 immediately. After release, 7 more edges pass before `ready`=1, and r1–r7 read 0x00.
- Generic sizing, N=16, A=4: fill r1–r15 with the value `addr*0x1111` (0x1111…0xFFFF), then read all back → exact match. `clr` then takes 15 edges before `ready` rises again.

Source files
------------

// File: rtl/regfile_p.sv
// regfile_p: 2^A x N register file, %0 reads zero, 2 async reads / 1 sync write; clear engine zeroes r1..r(2^A-1) one per edge.
// ready low while clearing (writes ignored, reads return 0); optional same-cycle write-to-read bypass under `REGS_BYPASS_EN.
module regfile_p #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         clr,
  input  logic         w,
  input  logic [A-1:0] Waddr,
  input  logic [N-1:0] Wdata,
  input  logic [A-1:0] Raddr1,
  input  logic [A-1:0] Raddr2,
  output logic [N-1:0] Rdata1,
  output logic [N-1:0] Rdata2,
  output logic         ready
);

  localparam int R = 1 << A;
  localparam logic [A-1:0] LAST = {A{1'b1}};
  localparam logic [A-1:0] ONE  = A'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   cc_q, cc_d;
  logic           ready_q, ready_d;

  // %0 has no storage; the array is deliberately not reset.
  logic [N-1:0]   gpr_q [1:R-1];

  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [N-1:0]   wr_data;

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    wr_en   = 1'b0;
    wr_addr = Waddr;
    wr_data = Wdata;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cc_q;
        wr_data = '0;
        if (clr) begin
          cc_d = ONE;
        end else if (cc_q == LAST) begin
          state_d = RUN;
          cc_d    = ONE;
        end else begin
          cc_d = cc_q + ONE;
        end
      end
      RUN: begin
        // clr wins over a simultaneous write
        if (clr) begin
          state_d = CLEAR;
          cc_d    = ONE;
        end else if (w && (Waddr != '0)) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cc_d    = ONE;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= CLEAR;
      cc_q    <= ONE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      gpr_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [N-1:0] rd_port(input logic [A-1:0] ra);
    logic [N-1:0] v;
    if (!ready_q || (ra == '0)) begin
      v = '0;
    end else begin
      v = gpr_q[ra];
`ifdef REGS_BYPASS_EN
      if (w && (Waddr != '0) && (ra == Waddr)) begin
        v = Wdata;
      end
`else
`endif
    end
    return v;
  endfunction

  assign Rdata1 = rd_port(Raddr1);
  assign Rdata2 = rd_port(Raddr2);
  assign ready  = ready_q;

endmodule

// File: tb/tb_regfile_p.sv
// Scoreboard bench for regfile_p: an 8x8 instance (a) and a 16x16 instance (b) share clock and reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after a change or after a rising edge.
module tb_regfile_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nReset;

  logic        a_clr, a_w, a_ready;
  logic [2:0]  a_waddr, a_raddr1, a_raddr2;
  logic [7:0]  a_wdata, a_rdata1, a_rdata2;

  logic        b_clr, b_w, b_ready;
  logic [3:0]  b_waddr, b_raddr1, b_raddr2;
  logic [15:0] b_wdata, b_rdata1, b_rdata2;

  regfile_p #(.N(8), .A(3)) dut_a (
    .clk(clk), .nReset(nReset), .clr(a_clr), .w(a_w), .Waddr(a_waddr), .Wdata(a_wdata),
    .Raddr1(a_raddr1), .Raddr2(a_raddr2), .Rdata1(a_rdata1), .Rdata2(a_rdata2), .ready(a_ready)
  );

  regfile_p #(.N(16), .A(4)) dut_b (
    .clk(clk), .nReset(nReset), .clr(b_clr), .w(b_w), .Waddr(b_waddr), .Wdata(b_wdata),
    .Raddr1(b_raddr1), .Raddr2(b_raddr2), .Rdata1(b_rdata1), .Rdata2(b_rdata2), .ready(b_ready)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic rd_a(input int r1, input int r2, input logic [7:0] e1, input logic [7:0] e2, input string tag);
    a_raddr1 = 3'(r1);
    a_raddr2 = 3'(r2);
    sb_push($sformatf("%s_a_p1_r%0d", tag, r1), 32'(e1));
    sb_push($sformatf("%s_a_p2_r%0d", tag, r2), 32'(e2));
    #1;
    sb_pop(32'(a_rdata1));
    sb_pop(32'(a_rdata2));
  endtask

  task automatic rd_b(input int r1, input int r2, input logic [15:0] e1, input logic [15:0] e2, input string tag);
    b_raddr1 = 4'(r1);
    b_raddr2 = 4'(r2);
    sb_push($sformatf("%s_b_p1_r%0d", tag, r1), 32'(e1));
    sb_push($sformatf("%s_b_p2_r%0d", tag, r2), 32'(e2));
    #1;
    sb_pop(32'(b_rdata1));
    sb_pop(32'(b_rdata2));
  endtask

  task automatic rdy_a(input logic exp, input string tag);
    sb_push(tag, 32'(exp));
    sb_pop(32'(a_ready));
  endtask

  task automatic rdy_b(input logic exp, input string tag);
    sb_push(tag, 32'(exp));
    sb_pop(32'(b_ready));
  endtask

  task automatic wr_a(input int addr, input logic [7:0] data);
    a_w     = 1'b1;
    a_waddr = 3'(addr);
    a_wdata = data;
    @(negedge clk);
    a_w     = 1'b0;
  endtask

  task automatic wr_b(input int addr, input logic [15:0] data);
    b_w     = 1'b1;
    b_waddr = 4'(addr);
    b_wdata = data;
    @(negedge clk);
    b_w     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] hz_exp;

    nReset = 1'b1;
    a_clr = 0; a_w = 0; a_waddr = 0; a_wdata = 0; a_raddr1 = 3; a_raddr2 = 5;
    b_clr = 0; b_w = 0; b_waddr = 0; b_wdata = 0; b_raddr1 = 7; b_raddr2 = 9;

    // reset state
    #2 nReset = 1'b0;
    #1;
    rdy_a(1'b0, "rst_ready_a");
    rdy_b(1'b0, "rst_ready_b");
    rd_a(3, 5, 8'h00, 8'h00, "rst");
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    #1;
    rdy_a(1'b0, "clr0_ready");
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      rdy_a(k == 7, $sformatf("init_clear_edge%0d", k));
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd_a(i, 7 - i, 8'h00, 8'h00, "post_clear");

    // %0 protection and dual-port same-address read
    wr_a(0, 8'hAA);
    rd_a(0, 0, 8'h00, 8'h00, "r0_protect");
    wr_a(3, 8'h5C);
    rd_a(3, 3, 8'h5C, 8'h5C, "r3_both");

    // same-cycle write/read hazard
    wr_a(5, 8'h11);
`ifdef REGS_BYPASS_EN
    hz_exp = 8'h3F;
`else
    hz_exp = 8'h11;
`endif
    a_w = 1'b1; a_waddr = 3'd5; a_wdata = 8'h3F;
    rd_a(3, 5, 8'h5C, hz_exp, "hazard_pre");
    @(negedge clk);
    a_w = 1'b0;
    rd_a(5, 5, 8'h3F, 8'h3F, "hazard_post");

    // clr with a simultaneous write in RUN
    wr_a(2, 8'h77);
    rd_a(2, 2, 8'h77, 8'h77, "r2_set");
    a_clr = 1'b1; a_w = 1'b1; a_waddr = 3'd4; a_wdata = 8'h99;
    @(posedge clk);
    #1;
    rdy_a(1'b0, "clr_edge0");
    a_clr = 1'b0; a_w = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      rdy_a(k == 7, $sformatf("clr_edge%0d", k));
    end
    @(negedge clk);
    rd_a(2, 4, 8'h00, 8'h00, "after_clr");

    // refill, then async reset while in RUN: outputs drop with no clock edge
    for (int i = 1; i < 8; i++) wr_a(i, 8'(8'h10 * i + 1));
    rd_a(3, 7, 8'h31, 8'h71, "refill");
    nReset = 1'b0;
    #1;
    rdy_a(1'b0, "async_run_ready");
    sb_push("async_run_rdata1", 32'h0);
    sb_pop(32'(a_rdata1));
    #2 nReset = 1'b1;
    // three clear edges to reach cc=4, then reset again between edges
    repeat (3) @(posedge clk);
    #1;
    rdy_a(1'b0, "mid_clear_ready");
    nReset = 1'b0;
    #1;
    rdy_a(1'b0, "async_clear_ready");
    sb_push("async_clear_rdata2", 32'h0);
    sb_pop(32'(a_rdata2));
    #1 nReset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      rdy_a(k == 7, $sformatf("reclear_edge%0d", k));
    end
    @(negedge clk);
    for (int i = 1; i < 8; i++) rd_a(i, i, 8'h00, 8'h00, "reclear");

    // generic sizing N=16, A=4
    n = 0;
    while (!b_ready && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    rdy_b(1'b1, "b_ready_wait");
    @(negedge clk);
    for (int i = 1; i < 16; i++) wr_b(i, 16'(i * 16'h1111));
    for (int i = 0; i < 16; i++) rd_b(i, 15 - i, 16'(i * 16'h1111), 16'((15 - i) * 16'h1111), "fill");
    b_clr = 1'b1;
    @(posedge clk);
    #1;
    rdy_b(1'b0, "b_clr_edge0");
    b_clr = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      rdy_b(k == 15, $sformatf("b_clr_edge%0d", k));
    end
    @(negedge clk);
    rd_b(15, 1, 16'h0000, 16'h0000, "b_after_clr");
    rd_b(8, 8, 16'h0000, 16'h0000, "b_after_clr");

    if (sb_q.size() != 0) check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
